// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Multi-cycle WIDTH-bit adder that works one nibble per cycle.
//                It drives an external 4-bit carry-lookahead unit with
//                per-nibble propagate/generate and consumes that unit's
//                carries in the same cycle. It accumulates the sum, the
//                carry-out and the signed overflow.
//                Optional feature macro: NSA_SUBTRACT_EN adds a 'sub' input
//                that selects a - b.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic [3:0]       pi,
  output logic [3:0]       gi,
  output logic             cla_cin,
  input  logic [3:0]       cla_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

  // Reject operand widths that are not whole nibbles.
  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic             w_last;

  // Operand conditioning at capture: subtraction is a + ~b + 1.
`ifdef NSA_SUBTRACT_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_a_nib = r_a[4*r_idx +: 4];
  assign w_b_nib = r_b[4*r_idx +: 4];
  assign w_last  = (r_idx == c_last_idx);

  // State register; rst aborts any operation straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake/CLA-interface outputs. CLA inputs are idle outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    pi          = 4'd0;
    gi          = 4'd0;
    cla_cin     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pi      = w_a_nib ^ w_b_nib;
        gi      = w_a_nib & w_b_nib;
        cla_cin = r_carry;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, fold one nibble per RUN cycle, hold results in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
            sum     <= '0;
          end
        end
        ST_RUN: begin
          // Bit k of the nibble sums with the carry into bit k: cla_cin for
          // bit 0, otherwise the CLA carry out of bit k-1.
          sum[4*r_idx +: 4] <= pi ^ {cla_c[2:0], r_carry};
          r_carry           <= cla_c[3];
          if (w_last) begin
            r_idx    <= '0;
            cout     <= cla_c[3];
            overflow <= cla_c[3] ^ cla_c[2];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder (WIDTH=16) with a
//                behavioural 4-bit carry-lookahead unit attached. Expected
//                results come from a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int W       = 16;
  localparam int NIBBLES = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef NSA_SUBTRACT_EN
  logic         sub;
`endif
  logic [3:0]   pi;
  logic [3:0]   gi;
  logic         cla_cin;
  logic [3:0]   cla_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUBTRACT_EN
    .sub       (sub),
`endif
    .pi        (pi),
    .gi        (gi),
    .cla_cin   (cla_cin),
    .cla_c     (cla_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Behavioural CLA unit: carry out of each bit of the nibble.
  logic c1, c2, c3, c4;
  assign c1    = gi[0] | (pi[0] & cla_cin);
  assign c2    = gi[1] | (pi[1] & c1);
  assign c3    = gi[2] | (pi[2] & c2);
  assign c4    = gi[3] | (pi[3] & c3);
  assign cla_c = {c4, c3, c2, c1};

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input logic tsub);
    exp_t         e;
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    bb     = tsub ? ~tb_ : tb_;
    c      = tsub ? 1'b1 : tcin;
    full   = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c};
    e.s    = full[W-1:0];
    e.co   = full[W];
    e.ov   = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tcin, input logic tsub);
    logic [3:0] bnib;
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb_;
    cin      = tcin;
`ifdef NSA_SUBTRACT_EN
    sub      = tsub;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(ta, tb_, tcin, tsub));
    bnib = tsub ? ~tb_[3:0] : tb_[3:0];
    check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
    check("pi_nibble0", {28'd0, pi}, {28'd0, ta[3:0] ^ bnib});
  endtask

  // Counts edges from acceptance until out_valid; bounded.
  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, NIBBLES);
  endtask

  task automatic recv(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.s});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.co});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ov});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   bad;
    exp_t held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef NSA_SUBTRACT_EN
    sub       = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {16'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    check("rst_pi_gi",     {24'd0, pi, gi},    32'd0);
    check("rst_cla_cin",   {31'd0, cla_cin},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases.
    send(16'h1234, 16'h4321, 1'b0, 1'b0); wait_done(); recv("add_1234_4321");
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_done(); recv("ripple_ffff_1");
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0); wait_done(); recv("ovf_7fff_cin");
    send(16'h8000, 16'h8000, 1'b0, 1'b0); wait_done(); recv("neg_ovf_8000");

    // A few random additions.
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      wait_done();
      recv("random_add");
    end

    // Stall in DONE while pulsing in_valid with other operands.
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done();
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      a        = 16'hAAAA;
      b        = 16'h5555;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_sum",       {16'd0, sum},       {16'd0, held.s});
      check("hold_cout",      {31'd0, cout},      {31'd0, held.co});
      check("hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    recv("hold_release");

    // Reset in RUN with idx==2: no result, outputs cleared.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sum",       {16'd0, sum},       32'd0);
    check("abort_cout_ovf",  {30'd0, cout, overflow}, 32'd0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_result", bad, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0); wait_done(); recv("post_rst_1_1");

`ifdef NSA_SUBTRACT_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1); wait_done(); recv("sub_5_7");
    send(16'h8000, 16'h0001, 1'b1, 1'b1); wait_done(); recv("sub_8000_1");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
